fwd_ctrl: RTL and testbench

Forwarding and hazard control unit for the five-stage pipeline. It tracks the destination register, write-back enable and load flag of the instructions in EX, MEM and WB. For each instruction leaving ID it produces the registered operand-source selects that the EX-stage forwarding muxes consume in the following cycle. It also raises stall/bubble for load-use hazards and counts stall cycles.

---
 rtl/fwd_ctrl_pkg.sv | 29 ++
 rtl/fwd_ctrl_if.sv | 37 +++
 rtl/fwd_ctrl_match.sv | 29 ++
 rtl/fwd_ctrl.sv | 143 ++++++++++++++
 tb/tb_fwd_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_ctrl_pkg.sv
// Shared types and constants for the forwarding/hazard control unit.
package fwd_ctrl_pkg;

    // Width of the destination field held in a tracking entry. The top-level
    // REG_W parameter is expected to equal this value.
    localparam int DEST_W = 5;

    // EX-stage operand source selects.
    localparam logic [1:0] SEL_REG = 2'b00;  // register file value
    localparam logic [1:0] SEL_MEM = 2'b01;  // EX/MEM pipeline result
    localparam logic [1:0] SEL_WB  = 2'b10;  // MEM/WB pipeline result

    // One in-flight instruction as seen by the forwarding logic.
    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              wb_en;
        logic              mem_r;
    } entry_t;

    localparam entry_t ENTRY_NONE = '0;

    // True when entry p will write register s. r0 is hard-wired and never
    // produced by anybody.
    function automatic logic produces(entry_t p, logic [DEST_W-1:0] s);
        return p.valid && p.wb_en && (p.dest == s) && (s != '0);
    endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage request / EX-stage select bundle of the forwarding control unit.
interface fwd_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_mem_w;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r;
    logic             ex_flush;
    logic             pipe_hold;
    logic [1:0]       alu_1_sel;
    logic [1:0]       alu_2_sel;
    logic [1:0]       st_data_sel;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: presents the ID instruction, consumes selects and stall.
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_mem_w,
               id_dest, id_wb_en, id_mem_r, ex_flush, pipe_hold,
        input  alu_1_sel, alu_2_sel, st_data_sel, stall, bubble, stall_cnt
    );

    // Control unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_mem_w,
               id_dest, id_wb_en, id_mem_r, ex_flush, pipe_hold,
        output alu_1_sel, alu_2_sel, st_data_sel, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/fwd_ctrl_match.sv
// Producer match and newest-first select for a single source register.
module fwd_match
    import fwd_ctrl_pkg::*;
(
    input  entry_t            ex_ent,
    input  entry_t            mem_ent,
    input  logic [DEST_W-1:0] src,
    input  logic              en,
    output logic [1:0]        sel,
    output logic              load_hit,
    output logic              any_hit
);
    logic ex_m;
    logic mem_m;

    // EX producer is newer than MEM producer, so it wins.
    always_comb begin
        ex_m     = en & produces(ex_ent, src);
        mem_m    = en & produces(mem_ent, src);
        sel      = SEL_REG;
        if (ex_m) begin
            sel = SEL_MEM;
        end else if (mem_m) begin
            sel = SEL_WB;
        end
        load_hit = ex_m & ex_ent.mem_r;
        any_hit  = ex_m | mem_m;
    end
endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for a five-stage pipeline.
// Build option: define STORE_FWD_EN to forward store data; otherwise a store
// whose data register is still in flight stalls until it has been written.
module fwd_ctrl
    import fwd_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    fwd_ctrl_if.slave   bus
);
    entry_t            ex_q, ex_d;
    entry_t            mem_q, mem_d;
    entry_t            wb_q, wb_d;
    logic [1:0]        alu_1_sel_q, alu_1_sel_d;
    logic [1:0]        alu_2_sel_q, alu_2_sel_d;
    logic [1:0]        st_data_sel_q, st_data_sel_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Source 0: rs (ALU 1), 1: rt (ALU 2), 2: rt (store data).
    logic [DEST_W-1:0] src_w [3];
    logic [2:0]        en_w;
    logic [1:0]        sel_w [3];
    logic [2:0]        load_hit_w;
    logic [2:0]        any_hit_w;
    logic              hazard_w;
    logic              stall_w;
    logic              bubble_w;

    // Source registers and their use gating; an invalid ID slot uses nothing.
    always_comb begin
        src_w[0] = DEST_W'(bus.id_rs);
        src_w[1] = DEST_W'(bus.id_rt);
        src_w[2] = DEST_W'(bus.id_rt);
        en_w[0]  = bus.id_valid & bus.id_use_rs;
        en_w[1]  = bus.id_valid & bus.id_use_rt;
        en_w[2]  = bus.id_valid & bus.id_mem_w;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            fwd_match u_match (
                .ex_ent   (ex_q),
                .mem_ent  (mem_q),
                .src      (src_w[gi]),
                .en       (en_w[gi]),
                .sel      (sel_w[gi]),
                .load_hit (load_hit_w[gi]),
                .any_hit  (any_hit_w[gi])
            );
        end
    endgenerate

    // Hazard detection. A load's data is not ready in EX/MEM, so any used
    // source hitting a load in EX needs one stall cycle. A flush wins: the
    // instruction waiting in ID is being squashed anyway.
    always_comb begin
`ifdef STORE_FWD_EN
        hazard_w = |load_hit_w;
`else
        hazard_w = (|load_hit_w) | any_hit_w[2];
`endif
        stall_w  = hazard_w & ~bus.ex_flush;
        bubble_w = stall_w & ~bus.pipe_hold;
    end

    // Next state: advance the tracking pipe and register the ID selects,
    // unless the whole pipeline is frozen.
    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        alu_1_sel_d   = alu_1_sel_q;
        alu_2_sel_d   = alu_2_sel_q;
        st_data_sel_d = st_data_sel_q;
        stall_cnt_d   = stall_cnt_q;
        if (!bus.pipe_hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (bubble_w || bus.ex_flush) begin
                ex_d          = ENTRY_NONE;
                alu_1_sel_d   = SEL_REG;
                alu_2_sel_d   = SEL_REG;
                st_data_sel_d = SEL_REG;
            end else begin
                ex_d.valid    = bus.id_valid;
                ex_d.dest     = DEST_W'(bus.id_dest);
                ex_d.wb_en    = bus.id_wb_en;
                ex_d.mem_r    = bus.id_mem_r;
                alu_1_sel_d   = sel_w[0];
                alu_2_sel_d   = sel_w[1];
`ifdef STORE_FWD_EN
                st_data_sel_d = sel_w[2];
`else
                st_data_sel_d = SEL_REG;
`endif
            end
            if (bubble_w && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q          <= ENTRY_NONE;
            mem_q         <= ENTRY_NONE;
            wb_q          <= ENTRY_NONE;
            alu_1_sel_q   <= SEL_REG;
            alu_2_sel_q   <= SEL_REG;
            st_data_sel_q <= SEL_REG;
            stall_cnt_q   <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            alu_1_sel_q   <= alu_1_sel_d;
            alu_2_sel_q   <= alu_2_sel_d;
            st_data_sel_q <= st_data_sel_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.alu_1_sel   = alu_1_sel_q;
    assign bus.alu_2_sel   = alu_2_sel_q;
    assign bus.st_data_sel = st_data_sel_q;
    assign bus.stall       = stall_w;
    assign bus.bubble      = bubble_w;
    assign bus.stall_cnt   = stall_cnt_q;

    // WB is tracked for completeness only: the register file writes through
    // to same-cycle ID reads, so nothing is ever forwarded from it.
    logic unused_sink;
`ifdef STORE_FWD_EN
    assign unused_sink = ^{wb_q, any_hit_w};
`else
    assign unused_sink = ^{wb_q, any_hit_w[1:0], sel_w[2]};
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed scoreboard bench for fwd_ctrl. Each row drives one ID cycle and
// queues the outputs expected in that cycle; a monitor compares at negedge.
module tb_fwd_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 3;
    localparam int SAT   = 7;
`ifdef STORE_FWD_EN
    localparam int SC = 0;
`else
    localparam int SC = 2;
`endif
    localparam int C = 1 + SC;

    typedef struct {
        string      name;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] sd;
        logic       st;
        logic       bub;
        int         cnt;
    } exp_t;

    logic clk;
    logic rst;
    bit   flush_v;
    bit   hold_v;
    bit   rst_v;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    event chk_ev;

    fwd_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string f, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, f, act, exp);
        end
    endtask

    // Monitor: pops and compares one expectation per sample point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.name, "alu_1_sel", int'(bus.alu_1_sel), int'(e.a1));
                cmp(e.name, "alu_2_sel", int'(bus.alu_2_sel), int'(e.a2));
                cmp(e.name, "st_data_sel", int'(bus.st_data_sel), int'(e.sd));
                cmp(e.name, "stall", int'(bus.stall), int'(e.st));
                cmp(e.name, "bubble", int'(bus.bubble), int'(e.bub));
                cmp(e.name, "stall_cnt", int'(bus.stall_cnt), e.cnt);
                $display("chk %-10s a1=%0d a2=%0d sd=%0d stall=%0d bubble=%0d cnt=%0d",
                         e.name, bus.alu_1_sel, bus.alu_2_sel, bus.st_data_sel,
                         bus.stall, bus.bubble, bus.stall_cnt);
            end
        end
    end

    task automatic drive(input string nm, input bit v, input int rs, input int rt,
                         input bit urs, input bit urt, input bit mw, input int rd,
                         input bit wb, input bit mr,
                         input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] ed,
                         input bit est, input bit ebub, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rst_v;
        bus.id_valid  = v;
        bus.id_rs     = REG_W'(rs);
        bus.id_rt     = REG_W'(rt);
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_mem_w  = mw;
        bus.id_dest   = REG_W'(rd);
        bus.id_wb_en  = wb;
        bus.id_mem_r  = mr;
        bus.ex_flush  = flush_v;
        bus.pipe_hold = hold_v;
        e = '{nm, e1, e2, ed, est, ebub, ecnt};
        sb_q.push_back(e);
    endtask

    task automatic alu(input string nm, input int rd, input int rs, input int rt,
                       input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] ed,
                       input bit est, input bit ebub, input int ecnt);
        drive(nm, 1, rs, rt, 1, 1, 0, rd, 1, 0, e1, e2, ed, est, ebub, ecnt);
    endtask

    task automatic ld(input string nm, input int rd, input int rs,
                      input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] ed,
                      input bit est, input bit ebub, input int ecnt);
        drive(nm, 1, rs, 0, 1, 0, 0, rd, 1, 1, e1, e2, ed, est, ebub, ecnt);
    endtask

    task automatic sw(input string nm, input int rt, input int rs,
                      input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] ed,
                      input bit est, input bit ebub, input int ecnt);
        drive(nm, 1, rs, rt, 1, 0, 1, 0, 0, 0, e1, e2, ed, est, ebub, ecnt);
    endtask

    task automatic nop(input string nm,
                       input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] ed,
                       input bit est, input bit ebub, input int ecnt);
        drive(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e2, ed, est, ebub, ecnt);
    endtask

    initial begin
        exp_t e;
        int   n;
        checks   = 0;
        failures = 0;
        flush_v  = 0;
        hold_v   = 0;
        rst_v    = 0;
        rst      = 1'b0;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0;
        bus.id_use_rt = 0; bus.id_mem_w = 0; bus.id_dest = '0; bus.id_wb_en = 0;
        bus.id_mem_r = 0; bus.ex_flush = 0; bus.pipe_hold = 0;

        // Reset state, with a would-be hazard pattern on the inputs.
        ld ("rst_a", 7, 1, 0, 0, 0, 0, 0, 0);
        alu("rst_b", 8, 7, 1, 0, 0, 0, 0, 0, 0);
        rst_v = 1;

        // ALU chain and distance-2/3 dependencies.
        alu("add_r3", 3, 1, 2,   0, 0, 0, 0, 0, 0);
        alu("sub_r4", 4, 3, 5,   0, 0, 0, 0, 0, 0);
        nop("chain",             1, 0, 0, 0, 0, 0);
        alu("add_r3b", 3, 1, 1,  0, 0, 0, 0, 0, 0);
        nop("gap",               0, 0, 0, 0, 0, 0);
        alu("or_r6", 6, 2, 3,    0, 0, 0, 0, 0, 0);
        alu("dist3", 10, 11, 3,  0, 2, 0, 0, 0, 0);
        // Load-use.
        ld ("lw_r7", 7, 1,       0, 0, 0, 0, 0, 0);
        alu("lu_stall", 8, 7, 1, 0, 0, 0, 1, 1, 0);
        alu("lu_again", 8, 7, 1, 0, 0, 0, 0, 0, 1);
        // Priority and r0.
        alu("w9_a", 9, 0, 0,     2, 0, 0, 0, 0, 1);
        alu("w9_b", 9, 0, 0,     0, 0, 0, 0, 0, 1);
        alu("use_r9", 12, 9, 9,  0, 0, 0, 0, 0, 1);
        alu("w_r0", 0, 1, 1,     1, 1, 0, 0, 0, 1);
        alu("use_r0", 13, 0, 2,  0, 0, 0, 0, 0, 1);
        nop("r0_chk",            0, 0, 0, 0, 0, 1);
        // Store data.
        alu("add_r2", 2, 1, 1,   0, 0, 0, 0, 0, 1);
`ifdef STORE_FWD_EN
        sw ("sw_r2", 2, 3,       0, 0, 0, 0, 0, 1);
        nop("sw_chk",            0, 0, 1, 0, 0, 1);
`else
        sw ("sw_r2", 2, 3,       0, 0, 0, 1, 1, 1);
        sw ("sw_st2", 2, 3,      0, 0, 0, 1, 1, 2);
        sw ("sw_go", 2, 3,       0, 0, 0, 0, 0, 3);
        nop("sw_chk",            0, 0, 0, 0, 0, 3);
`endif
        // Flush during a load-use stall.
        ld ("f_lw", 7, 1,        0, 0, 0, 0, 0, C);
        flush_v = 1;
        alu("f_flush", 8, 7, 1,  0, 0, 0, 0, 0, C);
        flush_v = 0;
        alu("f_after", 14, 8, 7, 0, 0, 0, 0, 0, C);
        nop("f_chk",             0, 2, 0, 0, 0, C);
        // Hold for three cycles while a load-use stall is pending.
        alu("h_r15", 15, 1, 1,   0, 0, 0, 0, 0, C);
        ld ("h_lw16", 16, 15,    0, 0, 0, 0, 0, C);
        hold_v = 1;
        alu("hold1", 18, 16, 0,  1, 0, 0, 1, 0, C);
        alu("hold2", 18, 16, 0,  1, 0, 0, 1, 0, C);
        alu("hold3", 18, 16, 0,  1, 0, 0, 1, 0, C);
        hold_v = 0;
        alu("h_stall", 18, 16, 0, 1, 0, 0, 1, 1, C);
        alu("h_go", 18, 16, 0,   0, 0, 0, 0, 0, C + 1);
        nop("h_chk",             2, 0, 0, 0, 0, C + 1);
        // Asynchronous reset in the middle of a stall.
        ld ("r_lw19", 19, 1,     0, 0, 0, 0, 0, C + 1);
        alu("r_stall", 20, 19, 0, 0, 0, 0, 1, 1, C + 1);
        @(negedge clk);
        #2;
        rst   = 1'b0;
        rst_v = 0;
        #1;
        e = '{"async_rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 0};
        sb_q.push_back(e);
        ->chk_ev;
        rst_v = 1;
        alu("r_repres", 20, 19, 0, 0, 0, 0, 0, 0, 0);
        // Repeated load-use stalls until the counter saturates.
        for (int i = 0; i < 10; i++) begin
            ld ("sat_lw", 21, 1, (i == 0) ? 2'b00 : 2'b10, 0, 0, 0, 0, (i < SAT) ? i : SAT);
            alu("sat_st", 22, 21, 0, 0, 0, 0, 1, 1, (i < SAT) ? i : SAT);
            alu("sat_go", 22, 21, 0, 0, 0, 0, 0, 0, (i + 1 < SAT) ? i + 1 : SAT);
        end
        nop("sat_end",           2, 0, 0, 0, 0, SAT);

        // Drain the scoreboard within a bounded number of cycles.
        n = 0;
        while (sb_q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
